// File: rtl/cache_response_router.sv
// Return-path router: pairs in-order cache read responses with issue-time tags and delivers them per requestor.
// Optional macro CACHE_RESPONSE_ROUTER_ERROR_CHECK_EN enables the sticky router_error flag and orphan discard.
module cache_response_router #(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int DATA_WIDTH           = 512,
    parameter int META_WIDTH           = 32,
    parameter int TAG_FIFO_DEPTH       = 16,
    parameter int RESP_FIFO_DEPTH      = 16,
    localparam int ID_WIDTH = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            req_issue_valid,
    input  logic [ID_WIDTH-1:0]             req_issue_id,
    input  logic [META_WIDTH-1:0]           req_issue_meta,
    input  logic                            cache_resp_valid,
    input  logic [DATA_WIDTH-1:0]           cache_resp_data,
    output logic                            cache_resp_ready,
    output logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_valid,
    input  logic [NUM_MEMORY_REQUESTOR-1:0] mem_resp_ready,
    output logic [DATA_WIDTH-1:0]           mem_resp_data,
    output logic [META_WIDTH-1:0]           mem_resp_meta,
    output logic                            resp_done,
    output logic                            fifo_setup_signal,
    output logic                            router_error
);

    localparam int TAW   = $clog2(TAG_FIFO_DEPTH);
    localparam int RAW   = $clog2(RESP_FIFO_DEPTH);
    localparam int TAG_W = ID_WIDTH + META_WIDTH;
    localparam logic [TAW:0] TAG_FULL_CNT  = (TAW+1)'(TAG_FIFO_DEPTH);
    localparam logic [RAW:0] RSP_FULL_CNT  = (RAW+1)'(RESP_FIFO_DEPTH);
    localparam logic [RAW:0] RSP_READY_MAX = (RAW+1)'(RESP_FIFO_DEPTH - 3);

    typedef enum logic [1:0] {RTR_RESET, RTR_SETUP, RTR_IDLE, RTR_SEND} rtr_state_t;

    rtr_state_t                      r_state;
    logic                            r_in_valid;
    logic [DATA_WIDTH-1:0]           r_in_data;
    logic [TAG_W-1:0]                r_tag_mem [TAG_FIFO_DEPTH];
    logic [TAW:0]                    r_tag_wptr;
    logic [TAW:0]                    r_tag_rptr;
    logic [DATA_WIDTH-1:0]           r_rsp_mem [RESP_FIFO_DEPTH];
    logic [RAW:0]                    r_rsp_wptr;
    logic [RAW:0]                    r_rsp_rptr;
    logic                            r_cache_ready;
    logic [NUM_MEMORY_REQUESTOR-1:0] r_mem_valid;
    logic [DATA_WIDTH-1:0]           r_mem_data;
    logic [META_WIDTH-1:0]           r_mem_meta;
    logic [ID_WIDTH-1:0]             r_mem_id;
    logic                            r_done;
    logic                            r_setup;

    logic [TAW:0]                    w_tag_cnt;
    logic                            w_tag_empty;
    logic                            w_tag_full;
    logic [RAW:0]                    w_rsp_cnt;
    logic                            w_rsp_empty;
    logic                            w_rsp_full;
    logic [TAG_W-1:0]                w_tag_head;
    logic [ID_WIDTH-1:0]             w_tag_id;
    logic [META_WIDTH-1:0]           w_tag_meta;
    logic [DATA_WIDTH-1:0]           w_rsp_head;
    logic                            w_id_ok;
    logic                            w_both;
    logic                            w_tag_pop;
    logic                            w_rsp_pop;
    logic                            w_orphan_pop;
    logic                            w_tag_wr;
    logic                            w_rsp_wr;
    logic [NUM_MEMORY_REQUESTOR-1:0] w_onehot;

    assign w_tag_cnt   = r_tag_wptr - r_tag_rptr;
    assign w_tag_empty = (w_tag_cnt == '0);
    assign w_tag_full  = (w_tag_cnt == TAG_FULL_CNT);
    assign w_rsp_cnt   = r_rsp_wptr - r_rsp_rptr;
    assign w_rsp_empty = (w_rsp_cnt == '0);
    assign w_rsp_full  = (w_rsp_cnt == RSP_FULL_CNT);

    assign w_tag_head = r_tag_mem[r_tag_rptr[TAW-1:0]];
    assign w_tag_id   = w_tag_head[TAG_W-1 -: ID_WIDTH];
    assign w_tag_meta = w_tag_head[META_WIDTH-1:0];
    assign w_rsp_head = r_rsp_mem[r_rsp_rptr[RAW-1:0]];
    assign w_id_ok    = ({1'b0, w_tag_id} < (ID_WIDTH+1)'(NUM_MEMORY_REQUESTOR));
    assign w_onehot   = NUM_MEMORY_REQUESTOR'(1) << w_tag_id;

    assign w_both    = !w_rsp_empty && !w_tag_empty;
    assign w_tag_pop = (r_state == RTR_IDLE) && w_both;
    assign w_rsp_pop = (r_state == RTR_IDLE) && (w_both || w_orphan_pop);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_tag_wr  = req_issue_valid && (!w_tag_full || w_tag_pop);
    assign w_rsp_wr  = r_in_valid && (!w_rsp_full || w_rsp_pop);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= cache_resp_valid;
        end
        r_in_data <= cache_resp_data;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
        end else begin
            if (w_tag_wr)  r_tag_wptr <= r_tag_wptr + 1'b1;
            if (w_tag_pop) r_tag_rptr <= r_tag_rptr + 1'b1;
            if (w_rsp_wr)  r_rsp_wptr <= r_rsp_wptr + 1'b1;
            if (w_rsp_pop) r_rsp_rptr <= r_rsp_rptr + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_tag_wr) r_tag_mem[r_tag_wptr[TAW-1:0]] <= {req_issue_id, req_issue_meta};
        if (w_rsp_wr) r_rsp_mem[r_rsp_wptr[RAW-1:0]] <= r_in_data;
    end

    // Threshold leaves room for the two responses already in the input pipeline.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_cache_ready <= 1'b0;
        end else begin
            r_cache_ready <= (r_state != RTR_RESET) && (w_rsp_cnt <= RSP_READY_MAX);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state     <= RTR_RESET;
            r_setup     <= 1'b1;
            r_mem_valid <= '0;
            r_mem_data  <= '0;
            r_mem_meta  <= '0;
            r_mem_id    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RTR_RESET: begin
                    r_state <= RTR_SETUP;
                end
                RTR_SETUP: begin
                    r_state <= RTR_IDLE;
                    r_setup <= 1'b0;
                end
                RTR_IDLE: begin
                    if (w_both && w_id_ok) begin
                        r_mem_data  <= w_rsp_head;
                        r_mem_meta  <= w_tag_meta;
                        r_mem_id    <= w_tag_id;
                        r_mem_valid <= w_onehot;
                        r_state     <= RTR_SEND;
                    end
                end
                RTR_SEND: begin
                    if (mem_resp_ready[r_mem_id]) begin
                        r_mem_valid <= '0;
                        r_done      <= 1'b1;
                        r_state     <= RTR_IDLE;
                    end
                end
                default: r_state <= RTR_RESET;
            endcase
        end
    end

`ifdef CACHE_RESPONSE_ROUTER_ERROR_CHECK_EN
    logic r_orphan_seen;
    logic r_error;
    logic w_orphan_cond;
    logic w_tag_drop;
    logic w_rsp_drop;
    logic w_bad_id;

    assign w_orphan_cond = (r_state == RTR_IDLE) && !w_rsp_empty && w_tag_empty;
    assign w_orphan_pop  = w_orphan_cond && r_orphan_seen;
    assign w_tag_drop    = req_issue_valid && w_tag_full && !w_tag_pop;
    assign w_rsp_drop    = r_in_valid && w_rsp_full && !w_rsp_pop;
    assign w_bad_id      = w_tag_pop && !w_id_ok;

    // An orphan must persist for two consecutive idle cycles before it is discarded.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_orphan_seen <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_orphan_seen <= w_orphan_cond && !r_orphan_seen;
            if (w_tag_drop || w_rsp_drop || w_bad_id || w_orphan_pop) r_error <= 1'b1;
        end
    end

    assign router_error = r_error;
`else
    assign w_orphan_pop = 1'b0;
    assign router_error = 1'b0;
`endif

    assign cache_resp_ready  = r_cache_ready;
    assign mem_resp_valid    = r_mem_valid;
    assign mem_resp_data     = r_mem_data;
    assign mem_resp_meta     = r_mem_meta;
    assign resp_done         = r_done;
    assign fifo_setup_signal = r_setup;

endmodule

// File: tb/tb_cache_response_router.sv
// Directed bench for cache_response_router: reset/setup, routing, ordering, backpressure, reset abort, errors.
module tb_cache_response_router;

    localparam int N  = 2;
    localparam int DW = 512;
    localparam int MW = 32;

    logic          ap_clk = 1'b0;
    logic          areset;
    logic          req_issue_valid;
    logic [0:0]    req_issue_id;
    logic [MW-1:0] req_issue_meta;
    logic          cache_resp_valid;
    logic [DW-1:0] cache_resp_data;
    logic          cache_resp_ready;
    logic [N-1:0]  mem_resp_valid;
    logic [N-1:0]  mem_resp_ready;
    logic [DW-1:0] mem_resp_data;
    logic [MW-1:0] mem_resp_meta;
    logic          resp_done;
    logic          fifo_setup_signal;
    logic          router_error;

    int n_cmp = 0;
    int n_err = 0;

    cache_response_router #(
        .NUM_MEMORY_REQUESTOR(N),
        .DATA_WIDTH(DW),
        .META_WIDTH(MW),
        .TAG_FIFO_DEPTH(16),
        .RESP_FIFO_DEPTH(16)
    ) dut (
        .ap_clk(ap_clk),
        .areset(areset),
        .req_issue_valid(req_issue_valid),
        .req_issue_id(req_issue_id),
        .req_issue_meta(req_issue_meta),
        .cache_resp_valid(cache_resp_valid),
        .cache_resp_data(cache_resp_data),
        .cache_resp_ready(cache_resp_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .mem_resp_meta(mem_resp_meta),
        .resp_done(resp_done),
        .fifo_setup_signal(fifo_setup_signal),
        .router_error(router_error)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input logic [N-1:0] exp);
        int n;
        n = 0;
        while (mem_resp_valid == '0 && n < 30) begin
            step();
            n++;
        end
        chk(tag, DW'(mem_resp_valid), DW'(exp));
    endtask

    task automatic issue(input logic [0:0] id, input logic [MW-1:0] meta);
        req_issue_valid = 1'b1;
        req_issue_id    = id;
        req_issue_meta  = meta;
        step();
        req_issue_valid = 1'b0;
    endtask

    task automatic respond(input logic [DW-1:0] data);
        cache_resp_valid = 1'b1;
        cache_resp_data  = data;
        step();
        cache_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        step();
        areset = 1'b0;
        step();
        step();
    endtask

    initial begin
        int dones;
        int saw;
        areset           = 1'b1;
        req_issue_valid  = 1'b0;
        req_issue_id     = '0;
        req_issue_meta   = '0;
        cache_resp_valid = 1'b0;
        cache_resp_data  = '0;
        mem_resp_ready   = '0;

        // Reset and setup sequencing
        step();
        step();
        step();
        chk("rst_setup", DW'(fifo_setup_signal), DW'(1));
        chk("rst_ready", DW'(cache_resp_ready), DW'(0));
        chk("rst_valid", DW'(mem_resp_valid), DW'(0));
        chk("rst_done", DW'(resp_done), DW'(0));
        chk("rst_error", DW'(router_error), DW'(0));
        chk("rst_data", mem_resp_data, '0);
        areset = 1'b0;
        step();
        chk("setup1_setup", DW'(fifo_setup_signal), DW'(1));
        chk("setup1_ready", DW'(cache_resp_ready), DW'(0));
        step();
        chk("setup2_setup", DW'(fifo_setup_signal), DW'(0));
        chk("setup2_ready", DW'(cache_resp_ready), DW'(1));
        chk("setup2_valid", DW'(mem_resp_valid), DW'(0));

        // Single response path, latency 3 cycles
        mem_resp_ready = 2'b11;
        issue(1'b1, 32'hA5);
        respond(DW'(16'h1234));
        chk("single_c1_valid", DW'(mem_resp_valid), DW'(0));
        step();
        chk("single_c2_valid", DW'(mem_resp_valid), DW'(0));
        step();
        chk("single_c3_valid", DW'(mem_resp_valid), DW'(2'b10));
        chk("single_c3_data", mem_resp_data, DW'(16'h1234));
        chk("single_c3_meta", DW'(mem_resp_meta), DW'(32'hA5));
        chk("single_c3_done", DW'(resp_done), DW'(0));
        step();
        chk("single_c4_valid", DW'(mem_resp_valid), DW'(0));
        chk("single_c4_done", DW'(resp_done), DW'(1));
        step();
        chk("single_c5_done", DW'(resp_done), DW'(0));

        // Ordering with requestor 0 backpressured; requestor 1 ready is ignored meanwhile
        mem_resp_ready = 2'b10;
        issue(1'b0, 32'h10);
        issue(1'b1, 32'h11);
        issue(1'b0, 32'h12);
        respond(DW'(8'hD0));
        respond(DW'(8'hD1));
        respond(DW'(8'hD2));
        wait_valid("ord_d0_valid", 2'b01);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            chk("ord_hold_valid", DW'(mem_resp_valid), DW'(2'b01));
            chk("ord_hold_data", mem_resp_data, DW'(8'hD0));
            if (resp_done) dones++;
            step();
        end
        mem_resp_ready = 2'b11;
        step();
        if (resp_done) dones++;
        chk("ord_hs0_valid", DW'(mem_resp_valid), DW'(0));
        chk("ord_hs0_done", DW'(resp_done), DW'(1));
        step();
        if (resp_done) dones++;
        chk("ord_d1_valid", DW'(mem_resp_valid), DW'(2'b10));
        chk("ord_d1_data", mem_resp_data, DW'(8'hD1));
        chk("ord_d1_meta", DW'(mem_resp_meta), DW'(32'h11));
        step();
        if (resp_done) dones++;
        chk("ord_hs1_done", DW'(resp_done), DW'(1));
        step();
        if (resp_done) dones++;
        chk("ord_d2_valid", DW'(mem_resp_valid), DW'(2'b01));
        chk("ord_d2_data", mem_resp_data, DW'(8'hD2));
        chk("ord_d2_meta", DW'(mem_resp_meta), DW'(32'h12));
        step();
        if (resp_done) dones++;
        step();
        if (resp_done) dones++;
        chk("ord_done_count", DW'(dones), DW'(3));

        // Cache backpressure: 16 responses with no consumer
        mem_resp_ready = 2'b00;
        for (int i = 0; i < 16; i++) issue(1'b0, MW'(i));
        chk("bp_ready_before", DW'(cache_resp_ready), DW'(1));
        for (int i = 0; i < 16; i++) begin
            cache_resp_valid = 1'b1;
            cache_resp_data  = DW'(32'h100 + i);
            step();
        end
        cache_resp_valid = 1'b0;
        chk("bp_ready_occ13", DW'(cache_resp_ready), DW'(1));
        step();
        chk("bp_ready_occ14", DW'(cache_resp_ready), DW'(0));
        step();
        chk("bp_ready_low", DW'(cache_resp_ready), DW'(0));
        mem_resp_ready = 2'b01;
        for (int j = 0; j < 16; j++) begin
            wait_valid("bp_drain_valid", 2'b01);
            chk("bp_drain_data", mem_resp_data, DW'(32'h100 + j));
            chk("bp_drain_meta", DW'(mem_resp_meta), DW'(j));
            step();
            chk("bp_drain_done", DW'(resp_done), DW'(1));
        end
        step();
        step();
        chk("bp_ready_after", DW'(cache_resp_ready), DW'(1));
        chk("bp_valid_after", DW'(mem_resp_valid), DW'(0));

        // Response without a tag
        mem_resp_ready = 2'b11;
        respond(DW'(16'h0F0F));
        saw = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_resp_valid != '0) saw++;
            step();
        end
        chk("orph_no_valid", DW'(saw), DW'(0));
`ifdef CACHE_RESPONSE_ROUTER_ERROR_CHECK_EN
        chk("orph_error", DW'(router_error), DW'(1));
        issue(1'b1, 32'h99);
        respond(DW'(16'hABCD));
        wait_valid("orph_next_valid", 2'b10);
        chk("orph_next_data", mem_resp_data, DW'(16'hABCD));
`else
        chk("orph_error", DW'(router_error), DW'(0));
        issue(1'b1, 32'h99);
        wait_valid("orph_late_valid", 2'b10);
        chk("orph_late_data", mem_resp_data, DW'(16'h0F0F));
        chk("orph_late_meta", DW'(mem_resp_meta), DW'(32'h99));
`endif
        step();
        chk("orph_done", DW'(resp_done), DW'(1));
        step();

        // Reset during SEND aborts the transfer and flushes both FIFOs
        mem_resp_ready = 2'b00;
        issue(1'b1, 32'h77);
        issue(1'b0, 32'h78);
        respond(DW'(16'hBEEF));
        respond(DW'(16'hBEE0));
        wait_valid("mr_valid", 2'b10);
        areset = 1'b1;
        step();
        chk("mr_valid_drop", DW'(mem_resp_valid), DW'(0));
        chk("mr_no_done", DW'(resp_done), DW'(0));
        chk("mr_setup", DW'(fifo_setup_signal), DW'(1));
        chk("mr_error_clr", DW'(router_error), DW'(0));
        areset = 1'b0;
        step();
        chk("mr_setup_hold", DW'(fifo_setup_signal), DW'(1));
        step();
        chk("mr_setup_end", DW'(fifo_setup_signal), DW'(0));
        mem_resp_ready = 2'b11;
        saw = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_resp_valid != '0 || resp_done) saw++;
            step();
        end
        chk("mr_fifos_empty", DW'(saw), DW'(0));
        issue(1'b0, 32'h55);
        respond(DW'(16'hCAFE));
        wait_valid("mr_new_valid", 2'b01);
        chk("mr_new_data", mem_resp_data, DW'(16'hCAFE));
        chk("mr_new_meta", DW'(mem_resp_meta), DW'(32'h55));
        step();
        chk("mr_new_done", DW'(resp_done), DW'(1));

        // Tag FIFO overflow on the 17th outstanding issue
        do_reset();
        for (int i = 0; i < 16; i++) issue(1'b0, MW'(i));
        chk("ovf_error_at16", DW'(router_error), DW'(0));
        issue(1'b0, 32'h16);
`ifdef CACHE_RESPONSE_ROUTER_ERROR_CHECK_EN
        chk("ovf_error_at17", DW'(router_error), DW'(1));
        step();
        chk("ovf_error_sticky", DW'(router_error), DW'(1));
`else
        chk("ovf_error_at17", DW'(router_error), DW'(0));
`endif
        chk("ovf_no_valid", DW'(mem_resp_valid), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
